// File: rtl/mm_pkg.sv
// Shared types and default sizes for the matrix-multiply controller.
package mm_pkg;

  localparam int MM_DW_DEFAULT = 8;
  localparam int MM_N_DEFAULT  = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MAC,
    FLUSH,
    STORE,
    DONE
  } state_t;

endpackage

// File: rtl/mm_idx_cnt.sv
// Nested i/j/k index counter for the C = A*B sequencer.
// k counts MAC steps; j advances per stored element and wraps into i.
module mm_idx_cnt #(
  parameter int N  = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_all,
  input  logic          clr_k,
  input  logic          inc_k,
  input  logic          inc_j,
  output logic [AW-1:0] i,
  output logic [AW-1:0] j,
  output logic [AW-1:0] k,
  output logic          k_last,
  output logic          last_elem
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  assign k_last    = (k == LAST);
  assign last_elem = (i == LAST) && (j == LAST);

  // NOTE: non-blocking assignments keep every counter update referring to
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clr_all) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (clr_k) begin
        k <= '0;
      end else if (inc_k) begin
        k <= k_last ? '0 : k + AW'(1);
      end
      if (inc_j) begin
        if (j == LAST) begin
          j <= '0;
          i <= (i == LAST) ? '0 : i + AW'(1);
        end else begin
          j <= j + AW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mm_ctrl.sv
// Sequencer for C = A*B over N x N matrices: CLEAR, N x MAC, FLUSH, STORE per element.
// Optional macro MM_CTRL_PERF_EN adds the 32-bit cycleCnt busy-cycle counter.
module mm_ctrl
  import mm_pkg::*;
#(
  parameter int DW = MM_DW_DEFAULT,
  parameter int N  = MM_N_DEFAULT,
  parameter int AW = $clog2(N * N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] aAddr,
  output logic [AW-1:0] bAddr,
  output logic [AW-1:0] cAddr,
  output logic          accZero,
  output logic          accWriteEn,
  output logic          cWriteEn,
  output logic          busy,
  output logic          done
`ifdef MM_CTRL_PERF_EN
  ,
  output logic [31:0]   cycleCnt
`endif
);

  if (N < 2 || N > 16 || DW < 1) begin : g_param_check
    $error("mm_ctrl: N must be in 2..16 and DW at least 1");
  end

  localparam logic [AW-1:0] NW = AW'(N);

  state_t        state;
  logic [AW-1:0] i, j, k;
  logic          k_last, last_elem;
  logic          start_ok;
  logic [AW-1:0] k_nxt, row_base;

  assign start_ok = (state == IDLE) && start && !abort;
  assign k_nxt    = k + AW'(1);
  assign row_base = i * NW;

  mm_idx_cnt #(
    .N (N),
    .AW(AW)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clr_all  (start_ok),
    .clr_k    (state == CLEAR),
    .inc_k    (state == MAC),
    .inc_j    ((state == STORE) && !abort),
    .i        (i),
    .j        (j),
    .k        (k),
    .k_last   (k_last),
    .last_elem(last_elem)
  );

  // Outputs are set on the edge that enters a state, so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      aAddr      <= '0;
      bAddr      <= '0;
      cAddr      <= '0;
      accZero    <= 1'b0;
      accWriteEn <= 1'b0;
      cWriteEn   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      accZero    <= 1'b0;
      cWriteEn   <= 1'b0;
      done       <= 1'b0;
      // One-cycle-delayed MAC indicator covers the operand RAM read latency.
      accWriteEn <= (state == MAC) && !abort;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= CLEAR;
              accZero <= 1'b1;
              busy    <= 1'b1;
            end
          end
          CLEAR: begin
            state <= MAC;
            aAddr <= row_base;
            bAddr <= j;
          end
          MAC: begin
            if (k_last) begin
              state <= FLUSH;
            end else begin
              aAddr <= row_base + k_nxt;
              bAddr <= k_nxt * NW + j;
            end
          end
          FLUSH: begin
            state    <= STORE;
            cWriteEn <= 1'b1;
            cAddr    <= row_base + j;
          end
          STORE: begin
            if (last_elem) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= CLEAR;
              accZero <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef MM_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleCnt <= '0;
    end else if (start_ok) begin
      cycleCnt <= '0;
    end else if (busy) begin
      cycleCnt <= cycleCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_ctrl.sv
// Directed bench for mm_ctrl at N=2: full-run vector table plus abort/reset/start corner cases.
module tb_mm_ctrl;

  localparam int N        = 2;
  localparam int AW       = 2;
  localparam int RUN_ROWS = 22;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [AW-1:0] aAddr, bAddr, cAddr;
  logic          accZero, accWriteEn, cWriteEn, busy, done;
`ifdef MM_CTRL_PERF_EN
  logic [31:0]   cycleCnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] c;
    logic          az;
    logic          awe;
    logic          cwe;
    logic          busy;
    logic          done;
  } outs_t;

  typedef struct {
    logic  start;
    logic  abort;
    outs_t exp;
  } vec_t;

  vec_t vecs[RUN_ROWS];

  always #5 clk = ~clk;

  mm_ctrl #(
    .DW(8),
    .N (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .aAddr     (aAddr),
    .bAddr     (bAddr),
    .cAddr     (cAddr),
    .accZero   (accZero),
    .accWriteEn(accWriteEn),
    .cWriteEn  (cWriteEn),
    .busy      (busy),
    .done      (done)
`ifdef MM_CTRL_PERF_EN
    ,
    .cycleCnt  (cycleCnt)
`endif
  );

  function automatic outs_t sample();
    outs_t o;
    o.a    = aAddr;
    o.b    = bAddr;
    o.c    = cAddr;
    o.az   = accZero;
    o.awe  = accWriteEn;
    o.cwe  = cWriteEn;
    o.busy = busy;
    o.done = done;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected per-cycle outputs of one full N=2 run, row r = cycle r after start acceptance.
  task automatic build_table();
    logic [AW-1:0] a = '0;
    logic [AW-1:0] b = '0;
    logic [AW-1:0] c = '0;
    for (int r = 0; r < RUN_ROWS; r++) begin
      int    e;
      int    p;
      int    ii;
      int    jj;
      outs_t o;
      e  = r / 5;
      p  = r % 5;
      ii = e / N;
      jj = e % N;
      o  = '0;
      if (r < 20) begin
        o.busy = 1'b1;
        case (p)
          0: o.az = 1'b1;
          1: begin
            a = AW'(ii * N);
            b = AW'(jj);
          end
          2: begin
            a     = AW'(ii * N + 1);
            b     = AW'(N + jj);
            o.awe = 1'b1;
          end
          3: o.awe = 1'b1;
          4: begin
            o.cwe = 1'b1;
            c     = AW'(e);
          end
          default: ;
        endcase
      end else if (r == 20) begin
        o.busy = 1'b1;
        o.done = 1'b1;
      end
      o.a           = a;
      o.b           = b;
      o.c           = c;
      vecs[r].start = (r == 0);
      vecs[r].abort = 1'b0;
      vecs[r].exp   = o;
    end
  endtask

  task automatic run_table(input string tag);
    for (int r = 0; r < RUN_ROWS; r++) begin
      start = vecs[r].start;
      abort = vecs[r].abort;
      @(posedge clk);
      #1;
      check($sformatf("%s row %0d", tag, r), 32'(sample()), 32'(vecs[r].exp));
    end
    start = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int done_cnt;
    int cwe_cnt;

    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    build_table();

    step(3);
    check("reset outputs", 32'(sample()), 32'(0));
`ifdef MM_CTRL_PERF_EN
    check("reset cycleCnt", cycleCnt, 32'd0);
`endif
    rst = 1'b0;
    step(1);

    // Full run from a single start pulse: cAddr 0..3, element (1,0) addressing, 21-cycle span.
    run_table("run1");
`ifdef MM_CTRL_PERF_EN
    check("cycleCnt after done", cycleCnt, 32'd21);
    step(3);
    check("cycleCnt holds in idle", cycleCnt, 32'd21);
`endif

    // Start held high: one done in the first run, restart only after the idle cycle.
    start = 1'b1;
    step(1);
    check("held start clear", 32'({accZero, busy}), 32'(2'b11));
    done_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (done) done_cnt++;
    end
    check("held start done at cycle 20", 32'(done), 32'(1));
    check("held start done count", 32'(done_cnt), 32'(1));
    step(1);
    check("held start idle gap", 32'({busy, accZero}), 32'(2'b00));
    step(1);
    check("held start second run", 32'({busy, accZero}), 32'(2'b11));
`ifdef MM_CTRL_PERF_EN
    check("cycleCnt cleared on accept", cycleCnt, 32'd0);
`endif
    start = 1'b0;
    abort = 1'b1;
    step(1);
    check("abort in clear", 32'({busy, accZero, accWriteEn, cWriteEn, done}), 32'(0));

    // Abort has priority over start in IDLE.
    start = 1'b1;
    step(1);
    check("abort beats start", 32'({busy, accZero}), 32'(0));
    abort = 1'b0;
    start = 1'b0;
    step(2);

    // Abort in the MAC phase of the second element.
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
    check("mac of element 1 addr", 32'({aAddr, bAddr, accWriteEn}), 32'({2'd0, 2'd1, 1'b0}));
    abort = 1'b1;
    step(1);
    check("abort strobes cleared", 32'({busy, accZero, accWriteEn, cWriteEn, done}), 32'(0));
    abort   = 1'b0;
    done_cnt = 0;
    cwe_cnt  = 0;
    for (int c = 0; c < 30; c++) begin
      step(1);
      if (done) done_cnt++;
      if (cWriteEn) cwe_cnt++;
    end
    check("no cWriteEn after abort", 32'(cwe_cnt), 32'(0));
    check("no done after abort", 32'(done_cnt), 32'(0));
    check("idle after abort", 32'(busy), 32'(0));

    // Reset asserted in STORE clears outputs without a clock edge; next run is complete.
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    check("store before reset", 32'({cWriteEn, cAddr}), 32'({1'b1, 2'd0}));
    #2;
    rst = 1'b1;
    #1;
    check("async reset in store", 32'(sample()), 32'(0));
`ifdef MM_CTRL_PERF_EN
    check("async reset cycleCnt", cycleCnt, 32'd0);
`endif
    step(1);
    rst = 1'b0;
    step(1);
    run_table("run2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mm_ctrl.md
MM_CTRL -- requirements
Module: mm_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning the matrix element width passed through to the datapath.
REQ-002 The block SHALL have parameter N, default 4, meaning the square matrix dimension, legal range 2..16.
REQ-003 The block SHALL have parameter AW, default clog2(N*N), meaning the element address width.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: begin one C=A*B run; sampled only in IDLE.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous cancel of the current run.
REQ-008 The block SHALL have port aAddr, output, AW bits: A read address, row-major, i*N+k.
REQ-009 The block SHALL have port bAddr, output, AW bits: B read address, row-major, k*N+j.
REQ-010 The block SHALL have port cAddr, output, AW bits: C write address, i*N+j.
REQ-011 The block SHALL have port accZero, output, 1 bit: clears the sum accumulator.
REQ-012 The block SHALL have port accWriteEn, output, 1 bit: loads the accumulator with sum+product.
REQ-013 The block SHALL have port cWriteEn, output, 1 bit: writes the accumulator value to C at cAddr.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse at run completion.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, MAC, FLUSH, STORE, DONE, all outputs registered.
REQ-017 IDLE: if start=1, go to CLEAR with i=j=k=0; otherwise stay in IDLE.
REQ-018 CLEAR: assert accZero for exactly one cycle, set k=0, go to MAC.
REQ-019 MAC: drive aAddr/bAddr from current i,j,k for N consecutive cycles, incrementing k; after k=N-1 go to FLUSH.
REQ-020 accWriteEn SHALL be a one-cycle-delayed copy of the MAC-state indicator, matching the 1-cycle synchronous operand RAM read latency; it is high in MAC cycles 2..N and in FLUSH.
REQ-021 FLUSH: only the final delayed accWriteEn is active; go to STORE.
REQ-022 STORE: assert cWriteEn with cAddr=i*N+j for one cycle; advance j, wrapping N-1->0 with i+1; if i=j=N-1, go to DONE, else go to CLEAR.
REQ-023 DONE: pulse done for one cycle, go to IDLE.
REQ-024 Each C element SHALL take exactly N+3 cycles; a full run SHALL take N*N*(N+3)+1 cycles from the first CLEAR to the done pulse inclusive.
REQ-025 accZero and accWriteEn SHALL never both be high in the same cycle; cWriteEn SHALL never coincide with either.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE next cycle, deassert all strobes, and SHALL NOT produce done; abort has priority over start.
REQ-028 Index arithmetic SHALL be done at AW bits; N*N-1 SHALL always fit without overflow.

Reset
REQ-029 While rst=1, the block SHALL hold state=IDLE; i, j, k, aAddr, bAddr, cAddr=0; accZero, accWriteEn, cWriteEn, busy, done=0; the delayed-valid register=0.
REQ-030 Reset asserted mid-run SHALL abandon the run immediately with no further write strobes.

Configuration
REQ-031 With macro MM_CTRL_PERF_EN defined, the block SHALL add output cycleCnt, 32 bits, cleared on start acceptance, incremented every busy cycle, holding its value in IDLE, reset to 0.
REQ-032 Without MM_CTRL_PERF_EN, the cycleCnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 Shared package mm_pkg SHALL hold the state enum type and the default DW and N constants.
REQ-034 The nested i/j/k counter with wrap and last-element flags SHALL be a sub-module, mm_idx_cnt.

Verification
REQ-035 N=2, single start pulse: done occurs exactly 21 cycles after the first CLEAR; cWriteEn occurs 4 times at cAddr 0, 1, 2, 3.
REQ-036 N=2, element (1,0): aAddr sequence 2, 3; bAddr sequence 0, 2; accWriteEn high in the following 2 cycles only.
REQ-037 Start held high throughout a run: exactly one run occurs, and a second run begins only on the cycle after done.
REQ-038 abort asserted during the MAC cycle of element 2: next cycle is IDLE, no cWriteEn occurs, done stays 0.
REQ-039 rst pulsed in STORE: all outputs are 0 asynchronously; a subsequent start produces a full, correct run.
REQ-040 With MM_CTRL_PERF_EN, N=2: cycleCnt=21 after done and holds at 21 in IDLE.
